// File: rtl/serie_paralelo_rx.sv
// Serial-to-parallel receiver: hunts for COM_CHAR, locks to word boundaries, then delivers payload words.
// Optional payload word counter is enabled by defining SP_BYTE_COUNT_EN.
module serie_paralelo_rx #(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] COM_CHAR   = 8'hBC,
    parameter int               LOCK_COUNT = 4
) (
    input  logic             clk_8f,
    input  logic             reset,
    input  logic             data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    output logic             active,
    output logic             byte_strobe
`ifdef SP_BYTE_COUNT_EN
    ,
    output logic [7:0]       byte_count
`endif
);

    localparam logic [1:0] HUNT   = 2'd0;
    localparam logic [1:0] SYNC   = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;

    localparam logic [2:0] LAST_BIT = 3'(WIDTH - 1);
    localparam logic [3:0] LOCK_CNT = 4'(LOCK_COUNT);

    logic [1:0]       state;
    logic [WIDTH-2:0] sr;
    logic [2:0]       bit_cnt;
    logic [3:0]       bc_cnt;
    logic [WIDTH-1:0] w;
    logic             word_done;

    // Candidate word includes the bit being sampled on this edge
    assign w         = {sr, data_in};
    assign word_done = (bit_cnt == LAST_BIT);

    always_ff @(posedge clk_8f or posedge reset) begin
        if (reset) begin
            state       <= HUNT;
            sr          <= '0;
            bit_cnt     <= '0;
            bc_cnt      <= '0;
            data_out    <= '0;
            valid_out   <= 1'b0;
            active      <= 1'b0;
            byte_strobe <= 1'b0;
`ifdef SP_BYTE_COUNT_EN
            byte_count  <= '0;
`endif
        end else begin
            sr          <= w[WIDTH-2:0];
            bit_cnt     <= bit_cnt + 3'd1;
            byte_strobe <= 1'b0;
            case (state)
                HUNT: begin
                    if (w == COM_CHAR) begin
                        bit_cnt <= '0;
                        bc_cnt  <= 4'd1;
                        if (LOCK_COUNT == 1) begin
                            state  <= LOCKED;
                            active <= 1'b1;
                        end else begin
                            state <= SYNC;
                        end
                    end
                end
                SYNC: begin
                    // A mismatching word drops back to HUNT without being rescanned
                    if (word_done) begin
                        if (w == COM_CHAR) begin
                            bc_cnt <= bc_cnt + 4'd1;
                            if (bc_cnt + 4'd1 == LOCK_CNT) begin
                                state  <= LOCKED;
                                active <= 1'b1;
                            end
                        end else begin
                            state  <= HUNT;
                            bc_cnt <= '0;
                        end
                    end
                end
                LOCKED: begin
                    if (word_done) begin
                        byte_strobe <= 1'b1;
                        if (w != COM_CHAR) begin
                            data_out  <= w;
                            valid_out <= 1'b1;
`ifdef SP_BYTE_COUNT_EN
                            byte_count <= byte_count + 8'd1;
`endif
                        end else begin
                            valid_out <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= HUNT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serie_paralelo_rx.sv
// Directed bench for serie_paralelo_rx: reset, lock, payload delivery, false-lock recovery and mid-word reset.
module tb_serie_paralelo_rx;

    logic       clk_8f;
    logic       reset;
    logic       data_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;
    logic       byte_strobe;
`ifdef SP_BYTE_COUNT_EN
    logic [7:0] byte_count;
`endif

    int vectors;
    int miscompares;

    serie_paralelo_rx dut (
        .clk_8f      (clk_8f),
        .reset       (reset),
        .data_in     (data_in),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .active      (active),
        .byte_strobe (byte_strobe)
`ifdef SP_BYTE_COUNT_EN
        ,
        .byte_count  (byte_count)
`endif
    );

    initial clk_8f = 1'b0;
    always #5 clk_8f = ~clk_8f;

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drives one bit just after a posedge, then samples 1 time unit after the next posedge
    task automatic applyStimulus(input logic b);
        data_in = b;
        @(posedge clk_8f);
        #1;
    endtask

    task automatic sendByte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) applyStimulus(v[i]);
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_data"}, 16'(data_out), 16'h00);
        checkOutput({tag, "_valid"}, 16'(valid_out), 16'h0);
        checkOutput({tag, "_active"}, 16'(active), 16'h0);
        checkOutput({tag, "_strobe"}, 16'(byte_strobe), 16'h0);
`ifdef SP_BYTE_COUNT_EN
        checkOutput({tag, "_count"}, 16'(byte_count), 16'h00);
`endif
    endtask

    task automatic doReset(input string tag);
        reset = 1'b1;
        #1;
        checkIdle(tag);
        @(posedge clk_8f);
        #1;
        reset = 1'b0;
    endtask

    task automatic lockUp(input string tag);
        for (int k = 0; k < 3; k++) begin
            sendByte(8'hBC);
            checkOutput({tag, "_pre_active"}, 16'(active), 16'h0);
        end
        sendByte(8'hBC);
        checkOutput({tag, "_active"}, 16'(active), 16'h1);
        checkOutput({tag, "_valid"}, 16'(valid_out), 16'h0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        data_in     = 1'b0;

        // Test 1: reset held with random serial data
        #1;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'($urandom_range(0, 1)));
            if (i % 4 == 3) checkIdle("t1_reset");
        end
        reset = 1'b0;

        // Test 2: four aligned COM words from the first edge
        lockUp("t2");
        checkOutput("t2_strobe_at_lock", 16'(byte_strobe), 16'h0);

        // Test 3: payload 01, 02, then COM
        sendByte(8'h01);
        checkOutput("t3_data01", 16'(data_out), 16'h01);
        checkOutput("t3_valid01", 16'(valid_out), 16'h1);
        checkOutput("t3_strobe", 16'(byte_strobe), 16'h1);
        applyStimulus(1'b0);
        checkOutput("t3_strobe_low", 16'(byte_strobe), 16'h0);
        checkOutput("t3_valid_hold", 16'(valid_out), 16'h1);
        checkOutput("t3_data_hold", 16'(data_out), 16'h01);
        for (int i = 6; i >= 0; i--) applyStimulus(i == 1);
        checkOutput("t3_data02", 16'(data_out), 16'h02);
        checkOutput("t3_valid02", 16'(valid_out), 16'h1);
        sendByte(8'hBC);
        checkOutput("t3_valid_com", 16'(valid_out), 16'h0);
        checkOutput("t3_data_held", 16'(data_out), 16'h02);
        checkOutput("t3_strobe_com", 16'(byte_strobe), 16'h1);

        // Test 4: misaligned garbage, 3 COMs, break with 55, then full lock
        doReset("t4_reset");
        applyStimulus(1'b1);
        applyStimulus(1'b0);
        applyStimulus(1'b1);
        for (int k = 0; k < 3; k++) sendByte(8'hBC);
        checkOutput("t4_active_3com", 16'(active), 16'h0);
        sendByte(8'h55);
        checkOutput("t4_active_55", 16'(active), 16'h0);
        lockUp("t4");
        checkOutput("t4_data", 16'(data_out), 16'h00);

        // Test 5: reset in the middle of A5 while locked
        for (int i = 7; i >= 4; i--) applyStimulus(8'hA5 >> i);
        doReset("t5_midword");
        for (int i = 3; i >= 0; i--) applyStimulus(8'hA5 >> i);
        checkOutput("t5_valid_after", 16'(valid_out), 16'h0);
        checkOutput("t5_data_after", 16'(data_out), 16'h00);
        lockUp("t5_relock");
        checkOutput("t5_data_relock", 16'(data_out), 16'h00);

`ifdef SP_BYTE_COUNT_EN
        // Test 6: payload counter over every byte value, then wrap
        doReset("t6_reset");
        lockUp("t6");
        for (int v = 0; v < 256; v++) begin
            sendByte(8'(v));
            if (v == 0) checkOutput("t6_count_first", 16'(byte_count), 16'h01);
        end
        checkOutput("t6_count_ff", 16'(byte_count), 16'hFF);
        sendByte(8'h10);
        checkOutput("t6_count_wrap", 16'(byte_count), 16'h00);
        checkOutput("t6_data10", 16'(data_out), 16'h10);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
